// File: rtl/ks_pkg.sv
// Shared types and constants for the 16-bit Kogge-Stone adder.
// Result bundle carried by the final sum/flag stage.
package ks_pkg;

  localparam int KS_W = 16;

  localparam logic [KS_W-1:0] KS_SAT_MAX = 16'h7FFF;
  localparam logic [KS_W-1:0] KS_SAT_MIN = 16'h8000;

  typedef struct packed {
    logic [KS_W-1:0] sum;
    logic            cout;
    logic            ovf;
    logic            p_all;
  } ks_res_t;

  // Clamp toward the sign the true result would have had.
  function automatic logic [KS_W-1:0] ks_sat(
    input logic [KS_W-1:0] sum_w
  );
    return sum_w[KS_W-1] ? KS_SAT_MAX : KS_SAT_MIN;
  endfunction

endpackage

// File: rtl/ks_sum_16b_pipe_if.sv
// Port bundle of the Kogge-Stone sum stage.
// Upstream stage-5 bus, downstream result bus and sticky control.
interface ks_sum_16b_pipe_if;
  import ks_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic            i_c0;
  logic [KS_W-1:0] i_p;
  logic [KS_W-1:0] i_g;
  logic            i_p_all;

  logic            o_valid;
  logic            i_ready;
  logic [KS_W-1:0] o_sum;
  logic            o_cout;
  logic            o_ovf;
  logic            o_p_all;

  logic            i_clr_sticky;
  logic            o_ovf_sticky;

  modport slave (
    input  i_valid,
    output o_ready,
    input  i_c0,
    input  i_p,
    input  i_g,
    input  i_p_all,
    output o_valid,
    input  i_ready,
    output o_sum,
    output o_cout,
    output o_ovf,
    output o_p_all,
    input  i_clr_sticky,
    output o_ovf_sticky
  );

  modport master (
    output i_valid,
    input  o_ready,
    output i_c0,
    output i_p,
    output i_g,
    output i_p_all,
    input  o_valid,
    output i_ready,
    input  o_sum,
    input  o_cout,
    input  o_ovf,
    input  o_p_all,
    output i_clr_sticky,
    input  o_ovf_sticky
  );

endinterface

// File: rtl/ks_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// Output register OR backed by one skid register SK; strict FIFO order.
module ks_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_ONE,
    SB_FULL
  } sb_st_e;

  sb_st_e       state_q, state_d;
  logic [W-1:0] or_q, or_d;
  logic [W-1:0] sk_q, sk_d;
  logic         in_fire;
  logic         out_fire;

  assign o_valid  = (state_q != SB_EMPTY);
  assign o_ready  = (state_q != SB_FULL);
  assign o_data   = or_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Data regs load only on a real transfer, so idle X never lands.
  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    unique case (state_q)
      SB_EMPTY: begin
        if (in_fire) begin
          or_d    = i_data;
          state_d = SB_ONE;
        end
      end
      SB_ONE: begin
        if (out_fire && in_fire) begin
          or_d = i_data;
        end else if (out_fire) begin
          state_d = SB_EMPTY;
        end else if (in_fire) begin
          sk_d    = i_data;
          state_d = SB_FULL;
        end
      end
      SB_FULL: begin
        if (out_fire) begin
          or_d    = sk_q;
          state_d = SB_ONE;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SB_EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
    end
  end

endmodule

// File: rtl/ks_sum_16b_pipe.sv
// Final sum/flag stage of the 16-bit Kogge-Stone adder.
// Forms sum, carry-out and overflow, optional saturation, skid-buffered.
module ks_sum_16b_pipe
  import ks_pkg::*;
#(
  parameter bit SAT_EN  = 1'b0,
  parameter bit CLR_PRI = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ks_sum_16b_pipe_if.slave  bus
);

  logic [KS_W-1:0] sum_w;
  logic            ovf_w;
  ks_res_t         res_w;
  ks_res_t         res_out;
  logic            in_fire;
  logic            set_w;
  logic            sticky_q, sticky_d;

  // Carry into bit k is the group generate of bit k-1.
  always_comb begin
    sum_w       = bus.i_p ^ {bus.i_g[KS_W-2:0], bus.i_c0};
    ovf_w       = bus.i_g[KS_W-2] ^ bus.i_g[KS_W-1];
    res_w.sum   = sum_w;
    res_w.cout  = bus.i_g[KS_W-1];
    res_w.ovf   = ovf_w;
    res_w.p_all = bus.i_p_all;
    if (SAT_EN && ovf_w) begin
      res_w.sum = ks_sat(sum_w);
    end
  end

  ks_skid_buf #(
    .W ($bits(ks_res_t))
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_data  (res_w),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (res_out)
  );

  assign in_fire = bus.i_valid & bus.o_ready;
  assign set_w   = in_fire & res_w.ovf;

  always_comb begin
    sticky_d = sticky_q;
    if (bus.i_clr_sticky && set_w) begin
      sticky_d = !CLR_PRI;
    end else if (bus.i_clr_sticky) begin
      sticky_d = 1'b0;
    end else if (set_w) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.o_sum        = res_out.sum;
  assign bus.o_cout       = res_out.cout;
  assign bus.o_ovf        = res_out.ovf;
  assign bus.o_p_all      = res_out.p_all;
  assign bus.o_ovf_sticky = sticky_q;

endmodule
